// File: rtl/bcd_seg7_scan.sv
// Two-digit multiplexed 7-segment driver with inter-slot dark gap,
// per-frame digit snapshot, leading-zero blanking and dash for non-BCD.
module bcd_seg7_scan #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int GAP_CYCLES   = 500,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int MAXC = (DIGIT_CYCLES > GAP_CYCLES) ?
                        DIGIT_CYCLES : GAP_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DLAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GLAST =
    CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_OFF  = ACTIVE_LOW ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {
    SHOW0,
    GAP0,
    SHOW1,
    GAP1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic          blz_q, blz_d;
  logic          prime_q, prime_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Next state, slot counter, snapshot capture and output image
  always_comb begin
    logic       adv;
    logic [1:0] act_an;
    logic [6:0] act_seg;
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    ones_d  = ones_q;
    tens_d  = tens_q;
    blz_d   = blz_q;
    prime_d = 1'b0;
    adv     = 1'b0;
    act_an  = 2'b00;
    act_seg = 7'h00;
    if (prime_q) begin
      // first edge after reset: load digits, hold slot at its start
      cnt_d  = '0;
      ones_d = digit_1;
      tens_d = digit_2;
      blz_d  = blank_lz;
    end else begin
      unique case (state_q)
        SHOW0: begin
          act_an  = 2'b01;
          act_seg = decode(ones_q);
          if (cnt_q == DLAST) begin
            adv     = 1'b1;
            state_d = (GAP_CYCLES == 0) ? SHOW1 : GAP0;
          end
        end
        GAP0: begin
          if (cnt_q == GLAST) begin
            adv     = 1'b1;
            state_d = SHOW1;
          end
        end
        SHOW1: begin
          if (!(blz_q && tens_q == 4'd0)) begin
            act_an  = 2'b10;
            act_seg = decode(tens_q);
          end
          if (cnt_q == DLAST) begin
            adv     = 1'b1;
            state_d = (GAP_CYCLES == 0) ? SHOW0 : GAP1;
          end
        end
        GAP1: begin
          if (cnt_q == GLAST) begin
            adv     = 1'b1;
            state_d = SHOW0;
          end
        end
      endcase
      if (adv) begin
        cnt_d = '0;
      end
      if (adv && state_d == SHOW0) begin
        ones_d = digit_1;
        tens_d = digit_2;
        blz_d  = blank_lz;
      end
    end
    an_d  = ACTIVE_LOW ? ~act_an : act_an;
    seg_d = ACTIVE_LOW ? ~act_seg : act_seg;
  end

  // State, snapshot and registered display outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= SHOW0;
      cnt_q   <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
      blz_q   <= 1'b0;
      prime_q <= 1'b1;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      blz_q   <= blz_d;
      prime_q <= prime_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
